mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Takes the execute result (ALU value or effective address), the opcode/funct3 and the rs2 store data.
- Performs RV32I loads and stores over a single-outstanding request/acknowledge data-memory port, including byte-lane alignment and load sign/zero extension.
- Non-memory results pass through unchanged, and the stage presents a registered writeback bundle to the register-file writer.

Parameters:
- TIMEOUT, 16: max cycles mem_req may stay unacknowledged before bus_err is raised.
- RESET_VECTOR_DATA, 32'h0000_0000: reset value of wb_data.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  execute bundle valid this cycle.
- in_ready  out  1  stage can accept a bundle this cycle.
- opcode  in  7  instruction opcode.
- funct3  in  3  width/sign selector.
- rd  in  5  destination register.
- result  in  32  ALU result or effective address.
- rs2Data  in  32  store data.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word-aligned address, {result[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-shifted store data.
- mem_ack  in  1  request completed; mem_rdata valid on loads.
- mem_rdata  in  32  load word.
- wb_valid  out  1  one-cycle pulse, bundle retired.
- wb_we  out  1  register write required.
- wb_rd  out  5  destination register.
- wb_data  out  32  writeback value.
- misaligned  out  1  pulses with wb_valid on an alignment fault.
- bus_err  out  1  pulses with wb_valid on a timeout.

Behaviour:
- Reset values: all outputs 0, except in_ready=1 and wb_data=RESET_VECTOR_DATA. State returns to IDLE and the timeout counter clears.
- A reset asserted mid-transaction drops mem_req on the next edge and discards the pending bundle. No wb_valid is produced for it.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - in_ready=1. A handshake occurs when in_valid&in_ready.
  - Non-memory opcode: on the next edge wb_valid=1, wb_data=result, wb_rd=rd, wb_we=(rd!=0). Stays in IDLE. Latency 1, throughput 1/cycle.
  - LOAD (7'b0000011) or STORE (7'b0100011): latch the bundle and go to REQ.
- Misalignment check:
  - Halfword with result[0]=1, or word with result[1:0]!=0, is misaligned.
  - A misaligned access skips REQ. The next edge gives wb_valid=1, misaligned=1, wb_we=0, wb_data=result (fault address), with no mem_req.
- REQ:
  - mem_req=1 and in_ready=0. mem_we, mem_addr, mem_be and mem_wdata are stable until ack.
  - mem_ack sampled high: go to RESP, latching mem_rdata.
  - Counter reaches TIMEOUT without ack: drop mem_req and go to RESP with bus_err=1, wb_we=0.
- RESP:
  - wb_valid=1 for one cycle. Return to IDLE with in_ready=1 in that same cycle, so a new bundle may be accepted.
- Byte enables (a = result[1:0]):
  - SB: 4'b0001<<a.
  - SH: 4'b0011<<a.
  - SW: 4'b1111.
  - mem_wdata is the store data replicated into the lanes: SB {4{rs2Data[7:0]}}, SH {2{rs2Data[15:0]}}, SW rs2Data.
- Load extraction:
  - Select byte a or halfword a[1] from the latched word.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
- Load writeback sets wb_we=(rd!=0). A store retires with wb_valid=1 and wb_we=0.
- Unsupported funct3 on LOAD/STORE (3'b011, 3'b110, 3'b111) retires next cycle with wb_we=0, misaligned=0 and no mem_req.
- mem_ack while not in REQ is ignored.
- Memory latency: 1 + N cycles to wb_valid, where N is cycles from mem_req to ack (N>=1). A same-cycle ack gives N=1.

Test Plan:
- ADD result 0x0000_0011, rd=5 -> next cycle wb_valid=1, wb_data=0x11, wb_we=1, wb_rd=5; back-to-back non-memory bundles retire every cycle.
- LB result=0x1003, mem_rdata=0x80FF_7F01 acked after 3 cycles -> mem_addr=0x1000, mem_be=0, wb_data=0xFFFF_FF80; the same access with LBU -> wb_data=0x0000_0080.
- SH result=0x2002, rs2Data=0x1234_ABCD -> mem_we=1, mem_be=4'b1100, mem_wdata=0xABCD_ABCD, wb_valid with wb_we=0 after ack.
- LW result=0x3001 -> no mem_req, next cycle misaligned=1, wb_data=0x3001, wb_we=0.
- LW with mem_ack never asserted, TIMEOUT=16 -> mem_req high exactly 16 cycles, then bus_err=1 with wb_valid, in_ready returns to 1.
- rst asserted while in REQ -> next edge mem_req=0, in_ready=1, no wb_valid; a subsequent ADD retires normally.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and register-file writeback.
// Issues RV32I loads/stores on a single-outstanding req/ack data port, aligns
// byte lanes, sign/zero-extends loads and passes non-memory results through.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             execute bundle handshake
//   opcode, funct3, rd            instruction fields
//   result                        ALU result or effective address
//   rs2Data                       store data
//   mem_req/mem_we/mem_addr/
//   mem_be/mem_wdata              memory request (held until mem_ack)
//   mem_ack/mem_rdata             memory completion and load word
//   wb_valid/wb_we/wb_rd/wb_data  registered writeback bundle (wb_valid pulses)
//   misaligned, bus_err           fault flags, pulse with wb_valid
module mem_stage #(
    parameter int unsigned TIMEOUT           = 16,
    parameter logic [31:0] RESET_VECTOR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [31:0] result,
    input  logic [31:0] rs2Data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_err
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state, state_nxt;

    logic          accept, is_mem, unsupported, misalign_in, timeout_hit;
    logic [CW-1:0] cnt;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_val;

    // Bundle latched for the duration of a memory access
    logic          q_we;
    logic [2:0]    q_funct3;
    logic [4:0]    q_rd;
    logic [31:0]   q_result;
    logic [3:0]    q_be;
    logic [31:0]   q_wdata;

    assign accept      = in_valid && in_ready;
    assign is_mem      = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign unsupported = is_mem && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
    assign misalign_in = is_mem && !unsupported &&
                         (((funct3[1:0] == 2'b01) && result[0]) ||
                          ((funct3[1:0] == 2'b10) && (result[1:0] != 2'b00)));
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // Store lane placement
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = rs2Data;
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << result[1:0];
                st_wdata = {4{rs2Data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << result[1:0];
                st_wdata = {2{rs2Data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction straight from the bus word on the ack edge
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (q_result[1:0])
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            2'd3:    ld_byte = mem_rdata[31:24];
            default: ;
        endcase
        ld_half = q_result[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (q_funct3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state. RESP accepts a new bundle exactly like IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE, RESP: begin
                if (accept && is_mem && !unsupported && !misalign_in)
                    state_nxt = REQ;
            end
            REQ: begin
                if (mem_ack || timeout_hit) state_nxt = RESP;
                else                        state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state != REQ);
        mem_req   = (state == REQ);
        mem_we    = '0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (state == REQ) begin
            mem_we    = q_we;
            mem_addr  = {q_result[31:2], 2'b00};
            mem_be    = q_be;
            mem_wdata = q_wdata;
        end
    end

    // Datapath: request latch, timeout counter, registered writeback bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            q_we       <= 1'b0;
            q_funct3   <= '0;
            q_rd       <= '0;
            q_result   <= '0;
            q_be       <= '0;
            q_wdata    <= '0;
            cnt        <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= RESET_VECTOR_DATA;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    cnt <= '0;
                    if (accept) begin
                        if (!is_mem) begin
                            wb_valid <= 1'b1;
                            wb_we    <= (rd != 5'd0);
                            wb_rd    <= rd;
                            wb_data  <= result;
                        end else if (unsupported || misalign_in) begin
                            wb_valid   <= 1'b1;
                            wb_rd      <= rd;
                            wb_data    <= result;
                            misaligned <= misalign_in;
                        end else begin
                            q_we     <= (opcode == OP_STORE);
                            q_funct3 <= funct3;
                            q_rd     <= rd;
                            q_result <= result;
                            q_be     <= (opcode == OP_STORE) ? st_be : 4'b0000;
                            q_wdata  <= (opcode == OP_STORE) ? st_wdata : 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= q_rd;
                        wb_we    <= !q_we && (q_rd != 5'd0);
                        wb_data  <= q_we ? q_result : ld_val;
                    end else if (timeout_hit) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= q_rd;
                        wb_data  <= q_result;
                        bus_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    localparam logic [31:0] RVD      = 32'hDEAD_0000;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [6:0]  OP_ALU   = 7'b0110011;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] result, rs2Data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, wb_we, misaligned, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.TIMEOUT(16), .RESET_VECTOR_DATA(RVD)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .rd(rd),
        .result(result), .rs2Data(rs2Data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] res, input logic [31:0] s2);
        in_valid = 1'b1;
        opcode   = op;
        funct3   = f3;
        rd       = r;
        result   = res;
        rs2Data  = s2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        n_checks++;
        if (in_ready !== 1'b1)
            begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++;
        if ({mem_req, mem_we, mem_be, wb_valid, wb_we, misaligned, bus_err} !== 10'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b want 0",
                  {mem_req, mem_we, mem_be, wb_valid, wb_we, misaligned, bus_err}); end
        n_checks++;
        if ({mem_addr, mem_wdata, wb_rd} !== 69'b0)
            begin n_fail++; $display("FAIL reset_buses: addr %h wdata %h rd %0d want 0",
                  mem_addr, mem_wdata, wb_rd); end
        n_checks++;
        if (wb_data !== RVD)
            begin n_fail++; $display("FAIL reset_wb_data: got %h want %h", wb_data, RVD); end
        rst = 1'b0;
        step;
    endtask

    task automatic test_alu;
        logic [4:0]  rds [4] = '{5'd5, 5'd6, 5'd0, 5'd31};
        logic [31:0] res [4] = '{32'h0000_0011, 32'hFFFF_0000, 32'h1234_5678, 32'h8000_0001};
        for (int i = 0; i < 4; i++) begin
            drive(OP_ALU, 3'b000, rds[i], res[i], 32'h0);
            step;
            n_checks++;
            if ({wb_valid, wb_we, wb_rd, in_ready, mem_req} !== {1'b1, (rds[i] != 5'd0), rds[i], 1'b1, 1'b0})
                begin n_fail++; $display("FAIL alu%0d_ctl: valid %b we %b rd %0d ready %b req %b want 1 %b %0d 1 0",
                      i, wb_valid, wb_we, wb_rd, in_ready, mem_req, (rds[i] != 5'd0), rds[i]); end
            n_checks++;
            if (wb_data !== res[i])
                begin n_fail++; $display("FAIL alu%0d_data: got %h want %h", i, wb_data, res[i]); end
        end
        in_valid = 1'b0;
        step;
        n_checks++;
        if ({wb_valid, wb_we} !== 2'b00)
            begin n_fail++; $display("FAIL alu_idle: valid %b we %b want 0 0", wb_valid, wb_we); end
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                            input int ack_dly, input logic [4:0] r, input logic [31:0] exp,
                            input logic [31:0] exp_addr, input string nm);
        drive(OP_LOAD, f3, r, addr, 32'hFFFF_FFFF);
        step;
        in_valid = 1'b0;
        n_checks++;
        if ({mem_req, mem_we, mem_be, in_ready, wb_valid} !== 8'b1000_0000)
            begin n_fail++; $display("FAIL %s_req: req %b we %b be %b ready %b wbv %b want 1 0 0000 0 0",
                  nm, mem_req, mem_we, mem_be, in_ready, wb_valid); end
        n_checks++;
        if ({mem_addr, mem_wdata} !== {exp_addr, 32'h0})
            begin n_fail++; $display("FAIL %s_addr: addr %h wdata %h want %h 0", nm, mem_addr, mem_wdata, exp_addr); end
        for (int i = 0; i < ack_dly; i++) begin
            step;
            n_checks++;
            if ({mem_req, wb_valid, mem_addr} !== {2'b10, exp_addr})
                begin n_fail++; $display("FAIL %s_hold%0d: req %b wbv %b addr %h", nm, i, mem_req, wb_valid, mem_addr); end
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        step;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0BAD_0BAD;
        n_checks++;
        if ({wb_valid, wb_we, wb_rd, mem_req, in_ready, bus_err, misaligned} !== {1'b1, (r != 5'd0), r, 4'b0100})
            begin n_fail++; $display("FAIL %s_wb_ctl: v %b we %b rd %0d req %b rdy %b be %b mis %b",
                  nm, wb_valid, wb_we, wb_rd, mem_req, in_ready, bus_err, misaligned); end
        n_checks++;
        if (wb_data !== exp)
            begin n_fail++; $display("FAIL %s_data: got %h want %h", nm, wb_data, exp); end
        step;
        n_checks++;
        if (wb_valid !== 1'b0)
            begin n_fail++; $display("FAIL %s_pulse: wb_valid %b want 0", nm, wb_valid); end
    endtask

    task automatic test_load;
        run_load(3'b000, 32'h0000_1003, 32'h80FF_7F01, 2, 5'd7,  32'hFFFF_FF80, 32'h0000_1000, "lb");
        run_load(3'b100, 32'h0000_1003, 32'h80FF_7F01, 2, 5'd7,  32'h0000_0080, 32'h0000_1000, "lbu");
        run_load(3'b000, 32'h0000_1001, 32'h80FF_7F01, 0, 5'd8,  32'h0000_007F, 32'h0000_1000, "lb_b1");
        run_load(3'b001, 32'h0000_2002, 32'h8001_1234, 1, 5'd9,  32'hFFFF_8001, 32'h0000_2000, "lh");
        run_load(3'b101, 32'h0000_2000, 32'h8001_9234, 0, 5'd10, 32'h0000_9234, 32'h0000_2000, "lhu");
        run_load(3'b010, 32'h0000_4000, 32'hCAFE_F00D, 3, 5'd0,  32'hCAFE_F00D, 32'h0000_4000, "lw_x0");
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd, input string nm);
        drive(OP_STORE, f3, 5'd3, addr, data);
        step;
        in_valid = 1'b0;
        n_checks++;
        if ({mem_req, mem_we, mem_be, in_ready} !== {2'b11, exp_be, 1'b0})
            begin n_fail++; $display("FAIL %s_req: req %b we %b be %b rdy %b want 1 1 %b 0",
                  nm, mem_req, mem_we, mem_be, in_ready, exp_be); end
        n_checks++;
        if (mem_wdata !== exp_wd)
            begin n_fail++; $display("FAIL %s_wdata: got %h want %h", nm, mem_wdata, exp_wd); end
        step;
        n_checks++;
        if ({mem_req, mem_be, mem_wdata} !== {1'b1, exp_be, exp_wd})
            begin n_fail++; $display("FAIL %s_stable: req %b be %b wdata %h", nm, mem_req, mem_be, mem_wdata); end
        mem_ack = 1'b1;
        step;
        mem_ack = 1'b0;
        n_checks++;
        if ({wb_valid, wb_we, mem_req, in_ready, bus_err} !== 5'b10010)
            begin n_fail++; $display("FAIL %s_wb: v %b we %b req %b rdy %b be %b want 1 0 0 1 0",
                  nm, wb_valid, wb_we, mem_req, in_ready, bus_err); end
        step;
    endtask

    task automatic test_store;
        run_store(3'b001, 32'h0000_2002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, "sh");
        run_store(3'b000, 32'h0000_2001, 32'hAABB_CC55, 4'b0010, 32'h5555_5555, "sb");
        run_store(3'b010, 32'h0000_2000, 32'h0102_0304, 4'b1111, 32'h0102_0304, "sw");
    endtask

    task automatic test_misaligned;
        logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
        logic [6:0]  ops [4] = '{OP_LOAD, OP_LOAD, OP_STORE, OP_LOAD};
        logic [31:0] adr [4] = '{32'h0000_3001, 32'h0000_3003, 32'h0000_5002, 32'h0000_4000};
        logic        mis [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], f3s[i], 5'd12, adr[i], 32'h0);
            step;
            in_valid = 1'b0;
            n_checks++;
            if ({wb_valid, misaligned, wb_we, mem_req, in_ready} !== {1'b1, mis[i], 3'b001})
                begin n_fail++; $display("FAIL mis%0d_ctl: v %b mis %b we %b req %b rdy %b want 1 %b 0 0 1",
                      i, wb_valid, misaligned, wb_we, mem_req, in_ready, mis[i]); end
            n_checks++;
            if (wb_data !== adr[i])
                begin n_fail++; $display("FAIL mis%0d_data: got %h want %h", i, wb_data, adr[i]); end
            step;
            n_checks++;
            if ({wb_valid, misaligned, mem_req} !== 3'b000)
                begin n_fail++; $display("FAIL mis%0d_after: v %b mis %b req %b", i, wb_valid, misaligned, mem_req); end
        end
    endtask

    task automatic test_timeout;
        int cycles = 0;
        drive(OP_LOAD, 3'b010, 5'd9, 32'h0000_6000, 32'h0);
        step;
        in_valid = 1'b0;
        for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
            cycles++;
            step;
        end
        n_checks++;
        if (cycles != 16)
            begin n_fail++; $display("FAIL timeout_len: mem_req high %0d cycles want 16", cycles); end
        n_checks++;
        if ({wb_valid, bus_err, wb_we, in_ready, misaligned} !== 5'b11010)
            begin n_fail++; $display("FAIL timeout_wb: v %b err %b we %b rdy %b mis %b want 1 1 0 1 0",
                  wb_valid, bus_err, wb_we, in_ready, misaligned); end
        step;
        n_checks++;
        if ({wb_valid, bus_err} !== 2'b00)
            begin n_fail++; $display("FAIL timeout_pulse: v %b err %b want 0 0", wb_valid, bus_err); end
    endtask

    task automatic test_ack_ignored;
        mem_ack = 1'b1;
        step;
        step;
        mem_ack = 1'b0;
        n_checks++;
        if ({wb_valid, mem_req, in_ready} !== 3'b001)
            begin n_fail++; $display("FAIL stray_ack: v %b req %b rdy %b want 0 0 1", wb_valid, mem_req, in_ready); end
    endtask

    task automatic test_reset_mid;
        drive(OP_LOAD, 3'b010, 5'd4, 32'h0000_7000, 32'h0);
        step;
        in_valid = 1'b0;
        step;
        rst = 1'b1;
        step;
        n_checks++;
        if ({mem_req, in_ready, wb_valid} !== 3'b010)
            begin n_fail++; $display("FAIL rst_mid: req %b rdy %b v %b want 0 1 0", mem_req, in_ready, wb_valid); end
        rst     = 1'b0;
        mem_ack = 1'b1;
        step;
        mem_ack = 1'b0;
        n_checks++;
        if ({wb_valid, mem_req} !== 2'b00)
            begin n_fail++; $display("FAIL rst_discard: v %b req %b want 0 0", wb_valid, mem_req); end
        drive(OP_ALU, 3'b000, 5'd3, 32'h0000_0077, 32'h0);
        step;
        in_valid = 1'b0;
        n_checks++;
        if ({wb_valid, wb_we, wb_rd, wb_data} !== {2'b11, 5'd3, 32'h0000_0077})
            begin n_fail++; $display("FAIL rst_then_add: v %b we %b rd %0d data %h want 1 1 3 00000077",
                  wb_valid, wb_we, wb_rd, wb_data); end
        step;
    endtask

    task automatic test_back_to_back;
        drive(OP_LOAD, 3'b010, 5'd20, 32'h0000_8000, 32'h0);
        step;
        in_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A_0001;
        step;
        mem_ack = 1'b0;
        n_checks++;
        if ({wb_valid, in_ready, wb_rd, wb_data} !== {2'b11, 5'd20, 32'h5A5A_0001})
            begin n_fail++; $display("FAIL b2b_load: v %b rdy %b rd %0d data %h", wb_valid, in_ready, wb_rd, wb_data); end
        drive(OP_ALU, 3'b000, 5'd21, 32'h0000_0042, 32'h0);
        step;
        in_valid = 1'b0;
        n_checks++;
        if ({wb_valid, wb_we, wb_rd, wb_data, mem_req} !== {2'b11, 5'd21, 32'h0000_0042, 1'b0})
            begin n_fail++; $display("FAIL b2b_alu: v %b we %b rd %0d data %h req %b",
                  wb_valid, wb_we, wb_rd, wb_data, mem_req); end
        step;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        opcode    = '0;
        funct3    = '0;
        rd        = '0;
        result    = '0;
        rs2Data   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        test_reset;
        test_alu;
        test_load;
        test_store;
        test_misaligned;
        test_timeout;
        test_ack_ignored;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
